// File: rtl/dma_periph_req_gen.sv
// Peripheral-side DMA req/clr model: TX FIFO drains, RX FIFO fills, each requests bursts.
// req registered one cycle after the entry condition; req holds until clr, then 2 low cycles min.
module dma_periph_req_gen #(
    parameter int DEPTH           = 64,
    parameter int BURST           = 8,
    parameter int TX_DRAIN_PERIOD = 4,
    parameter int RX_FILL_PERIOD  = 4,
    parameter int LW              = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          tx_en,
    input  logic          rx_en,
    output logic          periph_tx_req,
    input  logic          periph_tx_clr,
    output logic          periph_rx_req,
    input  logic          periph_rx_clr,
    output logic [LW-1:0] tx_level,
    output logic [LW-1:0] rx_level,
    output logic [15:0]   tx_req_cnt,
    output logic [15:0]   rx_req_cnt,
    output logic          tx_spurious_clr,
    output logic          rx_spurious_clr,
    output logic          rx_overflow
);

    localparam int TPW = (TX_DRAIN_PERIOD > 1) ? $clog2(TX_DRAIN_PERIOD) : 1;
    localparam int RPW = (RX_FILL_PERIOD > 1) ? $clog2(RX_FILL_PERIOD) : 1;
    localparam logic [LW-1:0] BURST_L = LW'(BURST);
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] ONE_L   = LW'(1);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, HOLD = 2'd2} state_t;

    state_t         tx_state, tx_state_nxt;
    state_t         rx_state, rx_state_nxt;
    logic [TPW-1:0] tx_pcnt;
    logic [RPW-1:0] rx_pcnt;
    logic           tx_tick, rx_tick;
    logic           tx_accept, rx_accept;
    logic           tx_drain, rx_fill;
    logic [LW-1:0]  tx_level_nxt, rx_level_nxt;

    assign tx_tick = tx_en && (tx_pcnt == TPW'(TX_DRAIN_PERIOD - 1));
    assign rx_tick = rx_en && (rx_pcnt == RPW'(RX_FILL_PERIOD - 1));

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tx_state <= IDLE;
            rx_state <= IDLE;
        end else begin
            tx_state <= tx_state_nxt;
            rx_state <= rx_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        tx_state_nxt = tx_state;
        rx_state_nxt = rx_state;
        case (tx_state)
            IDLE:    if (tx_en && ((DEPTH_L - tx_level) >= BURST_L)) tx_state_nxt = REQ;
            REQ:     if (periph_tx_clr) tx_state_nxt = HOLD;
            default: tx_state_nxt = IDLE;
        endcase
        case (rx_state)
            IDLE:    if (rx_en && (rx_level >= BURST_L)) rx_state_nxt = REQ;
            REQ:     if (periph_rx_clr) rx_state_nxt = HOLD;
            default: rx_state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from the registered state, so req is glitch-free
    always_comb begin
        periph_tx_req = (tx_state == REQ);
        periph_rx_req = (rx_state == REQ);
        tx_accept     = (tx_state == REQ) && periph_tx_clr;
        rx_accept     = (rx_state == REQ) && periph_rx_clr;
        tx_drain      = tx_tick && (tx_level != '0);
        rx_fill       = rx_tick && (rx_level != DEPTH_L);
        tx_level_nxt  = tx_level + (tx_accept ? BURST_L : '0) - (tx_drain ? ONE_L : '0);
        rx_level_nxt  = rx_level - (rx_accept ? BURST_L : '0) + (rx_fill ? ONE_L : '0);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            tx_pcnt         <= '0;
            rx_pcnt         <= '0;
            tx_level        <= '0;
            rx_level        <= '0;
            tx_req_cnt      <= '0;
            rx_req_cnt      <= '0;
            tx_spurious_clr <= 1'b0;
            rx_spurious_clr <= 1'b0;
            rx_overflow     <= 1'b0;
        end else begin
            if (tx_en) tx_pcnt <= tx_tick ? '0 : tx_pcnt + TPW'(1);
            if (rx_en) rx_pcnt <= rx_tick ? '0 : rx_pcnt + RPW'(1);
            tx_level <= tx_level_nxt;
            rx_level <= rx_level_nxt;
            if (tx_accept) tx_req_cnt <= tx_req_cnt + 16'd1;
            if (rx_accept) rx_req_cnt <= rx_req_cnt + 16'd1;
            if (periph_tx_clr && (tx_state != REQ)) tx_spurious_clr <= 1'b1;
            if (periph_rx_clr && (rx_state != REQ)) rx_spurious_clr <= 1'b1;
            if (rx_tick && (rx_level == DEPTH_L)) rx_overflow <= 1'b1;
        end
    end

endmodule

// File: doc/dma_periph_req_gen.md
Name: dma_periph_req_gen

Overview:
- Peripheral-side model of the DMA peripheral request/clear handshake. It drives periph_tx_req/periph_rx_req into the DMA and consumes the periph_tx_clr/periph_rx_clr pulses the DMA returns.
- Each direction models a FIFO with a fill level. The TX FIFO drains at a fixed rate and requests a burst when there is space for one. The RX FIFO fills at a fixed rate and requests a burst when one is available.
- Used in the DMA performance environment as the traffic source for peripheral-paced channels. It also provides sticky protocol-error flags and request counters for scoreboarding.

Parameters:
- DEPTH, 64: FIFO depth in entries, per direction.
- BURST, 8: entries moved per accepted clr. Legal range is 1..DEPTH.
- TX_DRAIN_PERIOD, 4: cycles per TX drain tick (one entry per tick). Must be ≥1.
- RX_FILL_PERIOD, 4: cycles per RX fill tick (one entry per tick). Must be ≥1.
- LW, $clog2(DEPTH+1): level width (derived).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  reset: synchronous, active-low.
- tx_en  in  1  enables TX drain and new TX requests.
- rx_en  in  1  enables RX fill and new RX requests.
- periph_tx_req  out  1  TX burst request to DMA.
- periph_tx_clr  in  1  DMA completed a TX burst (single-cycle pulse).
- periph_rx_req  out  1  RX burst request to DMA.
- periph_rx_clr  in  1  DMA completed an RX burst (single-cycle pulse).
- tx_level  out  LW  current TX occupancy.
- rx_level  out  LW  current RX occupancy.
- tx_req_cnt  out  16  count of accepted TX clr; wraps.
- rx_req_cnt  out  16  count of accepted RX clr; wraps.
- tx_spurious_clr  out  1  sticky: TX clr arrived while not in REQ.
- rx_spurious_clr  out  1  sticky: RX clr arrived while not in REQ.
- rx_overflow  out  1  sticky: RX fill tick occurred while rx_level==DEPTH.

Behaviour:
Reset
- When rstn is sampled low, every output, level, counter and period counter goes to 0, and both FSMs go to IDLE.
- This applies mid-handshake too: an outstanding req drops the cycle after rstn is sampled low.

Tick generation
- Per-direction period counter counts 0..PERIOD-1 while its enable is high and wraps to 0.
- A tick occurs in the cycle the counter equals PERIOD-1.
- When the enable is low, the counter holds its value and no ticks occur.

Per-channel FSM (same structure for TX and RX; req is a registered output equal to state==REQ)
- IDLE:
  - TX goes to REQ when tx_en && (DEPTH - tx_level) ≥ BURST.
  - RX goes to REQ when rx_en && rx_level ≥ BURST.
  - The condition uses the level value at the current edge.
- REQ:
  - req is held high until clr is sampled high. Deasserting the enable does not withdraw req.
  - On clr: go to HOLD, increment req_cnt, and apply BURST to the level (TX: +BURST, RX: -BURST).
- HOLD: unconditional for one cycle, req=0, then go to IDLE. This guarantees req is low for at least 2 cycles between bursts.
- clr in IDLE or HOLD sets the spurious flag. Level, counter and state are unchanged.

Level update (one next-state sum per cycle)
- TX: next = tx_level + (accepted clr ? BURST : 0) - (drain tick && tx_level>0 ? 1 : 0). The drain is gated by the current level, before the clr is added.
  - A simultaneous clr and tick therefore gives +BURST-1 when level>0, and +BURST when level==0.
  - The IDLE entry condition guarantees the result is ≤ DEPTH.
- RX: next = rx_level - (accepted clr ? BURST : 0) + (fill tick && rx_level<DEPTH ? 1 : 0).
  - A fill tick at rx_level==DEPTH sets rx_overflow and does not increment, even if a clr occurs in the same cycle.
  - The REQ entry condition guarantees no underflow.

Timing
- A condition met at edge N gives req=1 after edge N.
- clr sampled at edge M gives req=0 and the updated level after edge M. The earliest req re-assertion is after edge M+2.
- TX and RX are fully independent. Simultaneous activity on both channels has no interaction.

Sticky flags are cleared only by reset.

Test Plan:
All scenarios use the defaults (DEPTH=64, BURST=8, both periods 4).
- Reset mid-operation: hold rstn=0 for 2 cycles while periph_tx_req=1 and tx_level=24 → all outputs are 0 the cycle after the first low sample. Both reqs stay 0 until the enables are re-evaluated.
- TX basic: tx_en=1 at edge 0 with level 0 → periph_tx_req=1 after edge 1. Pulse periph_tx_clr at edge 5, which is not a drain tick → tx_level=8, req=0, tx_req_cnt=1 after edge 5, and req=1 again after edge 7.
- TX simultaneous: at tx_level=8 in REQ, periph_tx_clr coincides with a drain tick → tx_level=15. At tx_level=0, the same coincidence gives tx_level=8.
- RX fill: rx_en=1 from reset → the 8th fill tick occurs at edge 31 (rx_level=8) and periph_rx_req=1 after edge 32. clr on a non-tick cycle → rx_level=0 and rx_req_cnt=1.
- RX overflow: rx_en=1 with clr never sent → rx_level saturates at 64 after 256 cycles. The next tick sets rx_overflow=1 and rx_level stays 64. A clr then gives rx_level=56 and rx_overflow remains 1.
- Spurious clr: pulse periph_rx_clr with rx_en=0 (IDLE) → rx_spurious_clr=1, rx_level and rx_req_cnt unchanged. Pulsing periph_tx_clr in HOLD gives tx_spurious_clr=1.
